blur_window_feeder: RTL and testbench
=====================================

Name: blur_window_feeder

Overview:
- Upstream neighbour of the 5-tap blur stage in the edge-detector pixel path.
- Accepts a raster stream of 8-bit pixels, one per handshake, and keeps a sliding 5-pixel horizontal window.
- Presents each full window to the blur stage with a one-cycle enable, then holds it stable until the blur stage signals its final phase.
- Tracks column position so that windows never straddle two lines, and flags the last window of each line.

Parameters:
- LINE_WIDTH, 640, pixels per line; must be at least 5, smaller values are illegal.
- COL_BITS, 10, width of the column counter; must satisfy 2^COL_BITS >= LINE_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- pixel_valid  in  1  upstream has a pixel on pixel_in.
- pixel_in  in  8  incoming pixel value.
- line_start  in  1  qualifies pixel_in as column 0 of a new line; sampled only on an accepted pixel.
- final_stage  in  1  from the blur stage; high during its last phase.
- pixel_ready  out  1  feeder can accept a pixel this cycle.
- window  out  5x8 (packed [4:0][7:0])  window[0] is the oldest pixel, window[4] the newest.
- window_en  out  1  one-cycle pulse; the window is valid and the blur stage should start.
- last_window  out  1  window[4] is column LINE_WIDTH-1; meaningful only while window_en is high.

Behaviour:
- Reset (async, n_rst low) clears everything:
  - state = FILL, fill count = 0, column = 0, all window bytes = 0.
  - pixel_ready = 1, window_en = 0, last_window = 0.
- Accept rule: a pixel is accepted when pixel_valid && pixel_ready at a rising edge. pixel_valid while pixel_ready is low is ignored; upstream must hold its data.
- On accept:
  - Shift the window: window[i] <= window[i+1] for i = 0..3, and window[4] <= pixel_in.
  - Update column:
    - line_start = 1 → column 0.
    - Previous column = LINE_WIDTH-1 → wrap to 0.
    - Otherwise → column + 1.
  - Update fill count:
    - At column 0 → count = 1.
    - Otherwise → count + 1, saturating at 5.
- State FILL:
  - pixel_ready = 1, window_en = 0.
  - An accept whose updated count equals 5 moves to ISSUE. Otherwise stay in FILL.
- State ISSUE:
  - Lasts exactly one cycle. window_en = 1, pixel_ready = 0.
  - last_window = 1 if window[4] is at column LINE_WIDTH-1.
  - Next state is WAIT.
- State WAIT:
  - pixel_ready = 0, window_en = 0, window held stable.
  - final_stage = 1 moves to FILL. Otherwise stay in WAIT.
- final_stage in FILL or ISSUE is ignored.
- Latency and throughput:
  - 5th pixel of a line accepted at edge t → window_en high during cycle t+1.
  - Blur stage is in PHASE3 at t+3 → pixel_ready high again at t+4.
  - Sustained rate is one window per 4 cycles.
  - After the first window of a line, each accepted pixel produces a new window; there is no refill.
- Line boundary:
  - A pixel at column 0 (explicit line_start or automatic wrap) restarts the fill.
  - The 4 stale window bytes remain visible but no window_en is issued until 4 more pixels arrive.
  - A line produces exactly LINE_WIDTH-4 windows.
- line_start on a pixel already at column 0 (auto-wrap): identical behaviour, no double count.
- Reset mid-operation (any state, including WAIT): immediate return to the reset values above. No window_en is issued for the partial window.
- window, window_en and last_window are all registered outputs. There is no combinational path from the inputs to the outputs, except pixel_ready, which is a decode of the state register.

Test Plan:
- Reset, then stream 10,20,30,40,50 with pixel_valid held high → window_en for exactly 1 cycle, one cycle after the 5th accept; window[0..4] = 10,20,30,40,50; pixel_ready low until 1 cycle after final_stage.
- Continue from the previous scenario: pulse final_stage, then send 60 → next window_en with window = 20,30,40,50,60.
- Hold pixel_valid high during WAIT with final_stage low for 10 cycles → no accepts, window unchanged, no window_en.
- line_start with value 99 after 3 pixels of a line → no window_en until 4 more pixels arrive; first window = 99,a,b,c,d.
- LINE_WIDTH=8, send 16 pixels 0..15 with final_stage answering each window → 4 windows per line, last_window = 1 only on windows ending at pixels 7 and 15; the second line's first window = 8..12.
- Assert n_rst in WAIT with the window = 1..5 → window = 0, state FILL, pixel_ready = 1, window_en = 0; the next 5 pixels produce a normal window.

Source files
------------

// File: rtl/blur_window_feeder_if.sv
// Pixel-stream / window handshake between the raster source, the window feeder
// and the 5-tap blur stage.
interface blur_window_feeder_if;
  logic            pixel_valid;
  logic [7:0]      pixel_in;
  logic            line_start;
  logic            final_stage;
  logic            pixel_ready;
  logic [4:0][7:0] window;
  logic            window_en;
  logic            last_window;

  modport master (
    output pixel_valid, pixel_in, line_start, final_stage,
    input  pixel_ready, window, window_en, last_window
  );

  modport slave (
    input  pixel_valid, pixel_in, line_start, final_stage,
    output pixel_ready, window, window_en, last_window
  );
endinterface

// File: rtl/blur_window_feeder.sv
// Sliding 5-pixel horizontal window feeding the blur stage; one window per
// accepted pixel once a line has 5 pixels, held until the blur stage finishes.
module blur_window_feeder #(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned COL_BITS   = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  blur_window_feeder_if.slave bus
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LINE_WIDTH - 1);

  logic [1:0]          state;
  logic [2:0]          fill_cnt;
  logic [COL_BITS-1:0] col;
  logic [4:0][7:0]     win;
  logic                win_en_q;
  logic                last_q;

  logic                accept;
  logic [COL_BITS-1:0] next_col;
  logic [2:0]          next_cnt;

  assign bus.pixel_ready = (state == FILL);
  assign accept          = bus.pixel_valid && bus.pixel_ready;

  // col tracks the column of window[4]; column 0 restarts the fill count
  always_comb begin
    next_col = col + COL_BITS'(1);
    if (bus.line_start || col == LAST_COL)
      next_col = '0;
    next_cnt = fill_cnt;
    if (next_col == '0)
      next_cnt = 3'd1;
    else if (fill_cnt != 3'd5)
      next_cnt = fill_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      col      <= '0;
      win      <= '0;
      win_en_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      win_en_q <= 1'b0;
      last_q   <= 1'b0;
      if (accept) begin
        win      <= {bus.pixel_in, win[4:1]};
        col      <= next_col;
        fill_cnt <= next_cnt;
      end
      case (state)
        FILL: begin
          if (accept && next_cnt == 3'd5) begin
            state    <= ISSUE;
            win_en_q <= 1'b1;
            last_q   <= (next_col == LAST_COL);
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    if (bus.final_stage) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  assign bus.window      = win;
  assign bus.window_en   = win_en_q;
  assign bus.last_window = last_q;

endmodule

// File: tb/tb_blur_window_feeder.sv
// Directed bench for blur_window_feeder (LINE_WIDTH=8): driver pushes expected
// windows into a scoreboard, a negedge monitor pops on every window_en.
module tb_blur_window_feeder;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  blur_window_feeder_if bus();

  blur_window_feeder #(.LINE_WIDTH(8), .COL_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [39:0] win;
    logic        last;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] pk(input logic [7:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every window_en must match the oldest expected window
  exp_t e;
  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus.window_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_window_en: actual window %h at cycle %0d, required no window_en",
                 bus.window, cyc);
      end else begin
        e = sb.pop_front();
        check("window", bus.window, e.win);
        check("last_window", bus.last_window, e.last);
        check("window_en_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle();
    bus.pixel_valid = 1'b0;
    bus.line_start  = 1'b0;
  endtask

  // Present one pixel and wait for its accept; pixel_valid stays high afterwards
  task automatic send(input logic [7:0] v, input logic ls, input logic produces,
                      input logic [39:0] w, input logic lst);
    bit ok = 0;
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = v;
    bus.line_start  = ls;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.pixel_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: pixel %0d never accepted, required pixel_ready=1", v);
      idle();
      return;
    end
    @(posedge clk);
    #1;
    if (produces) sb.push_back('{win: w, last: lst, cyc: cyc});
    bus.line_start = 1'b0;
  endtask

  // Blur stage answer: called in the ISSUE cycle, final_stage high two cycles later
  task automatic answer(input bit chk);
    if (chk) check("ready_in_issue", bus.pixel_ready, 0);
    @(posedge clk); #1;
    if (chk) check("ready_in_wait", bus.pixel_ready, 0);
    @(posedge clk); #1;
    bus.final_stage = 1'b1;
    bus.pixel_valid = 1'b0;
    if (chk) check("ready_during_final", bus.pixel_ready, 0);
    @(posedge clk); #1;
    bus.final_stage = 1'b0;
    if (chk) check("ready_after_final", bus.pixel_ready, 1);
  endtask

  task automatic do_reset();
    n_rst           = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    bus.line_start  = 1'b0;
    bus.final_stage = 1'b0;
    @(posedge clk); #1;
    check("rst_window", bus.window, 0);
    check("rst_ready", bus.pixel_ready, 1);
    check("rst_window_en", bus.window_en, 0);
    check("rst_last", bus.last_window, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // First window of a line, then one more pixel -> one more window
    send(10, 1, 0, '0, 0);
    send(20, 0, 0, '0, 0);
    send(30, 0, 0, '0, 0);
    send(40, 0, 0, '0, 0);
    send(50, 0, 1, pk(10, 20, 30, 40, 50), 0);
    answer(1);
    send(60, 0, 1, pk(20, 30, 40, 50, 60), 0);

    // Valid held in WAIT: nothing accepted, window frozen
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'd77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("wait_ready", bus.pixel_ready, 0);
      check("wait_window", bus.window, pk(20, 30, 40, 50, 60));
    end
    answer(0);
    send(70, 0, 1, pk(30, 40, 50, 60, 70), 0);
    answer(0);
    send(80, 0, 1, pk(40, 50, 60, 70, 80), 1);
    answer(0);

    // Auto-wrap to column 0, then explicit line_start after 3 pixels
    send(1, 0, 0, '0, 0);
    send(2, 0, 0, '0, 0);
    send(3, 0, 0, '0, 0);
    send(99, 1, 0, '0, 0);
    send(4, 0, 0, '0, 0);
    send(5, 0, 0, '0, 0);
    send(6, 0, 0, '0, 0);
    send(7, 0, 1, pk(99, 4, 5, 6, 7), 0);
    answer(0);
    idle();

    // Two full lines 0..15; line_start also on pixel 8 which wraps anyway
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(8'(i), (i == 0 || i == 8), ((i % 8) >= 4),
           pk(8'(i - 4), 8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)), ((i % 8) == 7));
      if (i == 8) check("stale_window", bus.window, pk(4, 5, 6, 7, 8));
      if ((i % 8) >= 4) answer(0);
    end
    idle();

    // Reset while in WAIT
    do_reset();
    send(1, 1, 0, '0, 0);
    send(2, 0, 0, '0, 0);
    send(3, 0, 0, '0, 0);
    send(4, 0, 0, '0, 0);
    send(5, 0, 1, pk(1, 2, 3, 4, 5), 0);
    idle();
    @(posedge clk); #1;
    check("wait_window_pre_rst", bus.window, pk(1, 2, 3, 4, 5));
    check("wait_ready_pre_rst", bus.pixel_ready, 0);
    n_rst = 1'b0;
    #1;
    check("midrst_window", bus.window, 0);
    check("midrst_ready", bus.pixel_ready, 1);
    check("midrst_window_en", bus.window_en, 0);
    check("midrst_last", bus.last_window, 0);
    @(negedge clk);
    n_rst = 1'b1;
    send(21, 1, 0, '0, 0);
    send(22, 0, 0, '0, 0);
    send(23, 0, 0, '0, 0);
    send(24, 0, 0, '0, 0);
    send(25, 0, 1, pk(21, 22, 23, 24, 25), 0);
    answer(0);
    idle();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
